// File: rtl/pipe_skid_reg.sv
// Two-entry registered pipeline stage (skid buffer) with a valid/ready handshake.
// in_ready and out_valid are flops, so neither handshake side has a combinational path.
module pipe_skid_reg #(
  parameter int bus = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic [bus-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [bus-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:0]     count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } st_e;

  st_e            st;
  logic [bus-1:0] main_q;
  logic [bus-1:0] skid_q;
  logic           acc;
  logic           rel;

  assign acc      = in_valid & in_ready;
  assign rel      = out_valid & out_ready;
  assign out_data = main_q;
  assign count    = st;

  // The state encoding is the occupancy count, so count needs no extra logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      // main_q keeps its value; out_data is don't-care once out_valid drops.
      st        <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (st)
        EMPTY: begin
          if (acc) begin
            main_q    <= in_data;
            st        <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (acc && rel) begin
            main_q <= in_data;
          end else if (acc) begin
            skid_q   <= in_data;
            st       <= TWO;
            in_ready <= 1'b0;
          end else if (rel) begin
            st        <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          // in_ready is low here, so only a release can move the state.
          if (rel) begin
            main_q   <= skid_q;
            st       <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          st        <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  a_count_range : assert property (@(posedge clk) disable iff (!rst_n) st != 2'd3);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: reset, vector table, reset/flush corner
// sequences, and a random run against a queue-based occupancy model.
module tb_pipe_skid_reg;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] count;

  int n_chk;
  int n_fail;

  pipe_skid_reg #(.bus(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       iv;
    logic [3:0] d;
    logic       ordy;
    logic       ev;
    logic [3:0] ed;
    logic       eir;
    logic [1:0] ec;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [3:0] d, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  logic [3:0] q[$];
  logic       m_acc;
  logic       m_rel;
  logic       r_fl;
  logic       r_iv;
  logic       r_or;
  logic [3:0] r_d;
  int         delivered;

  initial begin
    n_chk = 0;
    n_fail = 0;
    delivered = 0;

    // vectors: {flush, in_valid, in_data, out_ready, exp out_valid, exp out_data, exp in_ready, exp count}
    tbl[0]  = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 1'b1, 2'd1};
    tbl[1]  = '{1'b0, 1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[2]  = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 4'h3, 1'b1, 2'd1};
    tbl[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0};
    tbl[4]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 4'hA, 1'b1, 2'd1};
    tbl[5]  = '{1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 4'hA, 1'b0, 2'd2};
    tbl[6]  = '{1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 4'hA, 1'b0, 2'd2};
    tbl[7]  = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 4'hB, 1'b1, 2'd1};
    tbl[8]  = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 4'hC, 1'b1, 2'd1};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0};
    tbl[10] = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 4'h5, 1'b1, 2'd1};
    tbl[11] = '{1'b0, 1'b1, 4'h6, 1'b0, 1'b1, 4'h5, 1'b0, 2'd2};
    tbl[12] = '{1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0};

    // Reset with a valid word pending at the input.
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 4'hF, 1'b1);
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_count", count, 0);

    // Streaming, back-pressure and flush vectors.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      step();
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].eir);
      chk($sformatf("vec%0d_count", i), count, tbl[i].ec);
      if (tbl[i].ev) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].ed);
    end

    // Asynchronous reset between edges while holding one word.
    drive(1'b0, 1'b1, 4'h9, 1'b0);
    step();
    chk("pre_async_count", count, 1);
    chk("pre_async_out_data", out_data, 4'h9);
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_count", count, 0);
    chk("async_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 4'h4, 1'b0);
    step();
    chk("after_rst_out_valid", out_valid, 1);
    chk("after_rst_out_data", out_data, 4'h4);
    chk("after_rst_count", count, 1);
    drive(1'b0, 1'b0, 4'h0, 1'b1);
    step();
    chk("drain_count", count, 0);

    // Random traffic against a FIFO occupancy model.
    q.delete();
    for (int c = 0; c < 1000; c++) begin
      r_iv = 1'($urandom_range(0, 1));
      r_or = 1'($urandom_range(0, 1));
      r_fl = ($urandom_range(0, 39) == 0);
      r_d  = 4'($urandom);
      drive(r_fl, r_iv, r_d, r_or);
      m_acc = r_iv && (q.size() < 2);
      m_rel = (q.size() > 0) && r_or;
      if (m_rel) begin
        chk("rnd_release_data", out_data, q[0]);
        delivered++;
      end
      step();
      if (r_fl) q.delete();
      else begin
        if (m_rel) void'(q.pop_front());
        if (m_acc) q.push_back(r_d);
      end
      chk("rnd_count", count, q.size());
      chk("rnd_out_valid", out_valid, q.size() > 0);
      chk("rnd_in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) chk("rnd_out_data", out_data, q[0]);
    end
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    if (delivered == 0) chk("rnd_any_delivered", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
